data_mem_port: RTL and testbench
================================

DATA_MEM_PORT -- requirements
Module: data_mem_port

Parameters
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h01000000, meaning the byte address of the first storage byte.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 262144, meaning storage size in 32-bit words; legal range is a power of two from 16 to 262144.
REQ-003 The block SHALL have parameter LATENCY, default 2, meaning the number of cycles from request acceptance to response; legal range is 1..8.

Interface
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  a request is present.
REQ-007 req_ready  out  1  the block can accept a request this cycle.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, little-endian, low bytes used for byte and halfword accesses.
REQ-010 req_we  in  1  1 = store, 0 = load.
REQ-011 req_size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-012 req_unsigned  in  1  load zero-extends when 1 and sign-extends when 0.
REQ-013 resp_valid  out  1  a response is present.
REQ-014 resp_ready  in  1  the consumer accepts the response.
REQ-015 resp_rdata  out  32  load data.
REQ-016 resp_err  out  1  the request faulted.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on an edge where req_valid=1 and req_ready=1.
REQ-019 On acceptance, the block SHALL capture addr, wdata, we, size and unsigned, load a 4-bit counter with LATENCY-1, and go to RESP if LATENCY=1, otherwise to WAIT.
REQ-020 In WAIT, the counter SHALL decrement each cycle; when it reaches 1, the next edge SHALL enter RESP.
REQ-021 As a result, resp_valid SHALL first be 1 exactly LATENCY cycles after the acceptance cycle.
REQ-022 The memory access SHALL occur on the edge that enters RESP: stores commit then, and load data is sampled then from the current contents.
REQ-023 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until the edge where resp_ready=1, which SHALL return the FSM to IDLE.
REQ-024 The minimum request spacing SHALL be LATENCY+1 cycles.
REQ-025 Storage SHALL be byte-addressed: byte k lives at BASE_ADDR+k, and word i covers bytes 4i..4i+3, little-endian.
REQ-026 All storage SHALL initialise to zero at time zero.
REQ-027 A request SHALL fault when any of these holds:
- req_size=11;
- a halfword access has addr[0]=1;
- a word access has addr[1:0]!=0;
- any addressed byte lies outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS-1].
REQ-028 A faulted request SHALL use the same latency as a normal request, SHALL NOT modify storage, and SHALL respond with resp_err=1 and resp_rdata=32'hBADB_ADFF.
REQ-029 A load response SHALL return the selected byte or halfword in the low bits, zero-extended or sign-extended from its MSB per the captured unsigned flag; word loads ignore unsigned.
REQ-030 A store SHALL modify only the addressed bytes, and its response SHALL have resp_rdata=0 and resp_err=0.
REQ-031 The range check SHALL use 33-bit arithmetic, so addresses near 32'hFFFFFFFF do not wrap into range.
REQ-032 Changes to the request inputs while not in IDLE SHALL have no effect.

Reset
REQ-033 When reset=1 at an edge, the FSM SHALL go to IDLE and the counter to 0.
REQ-034 The output values in reset and IDLE SHALL be: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-035 Reset SHALL NOT clear storage.
REQ-036 Reset in WAIT SHALL discard the request, so a pending store never commits; reset in RESP SHALL drop the response.
REQ-037 reset SHALL take priority over acceptance and over resp_ready in the same cycle.

Verification
REQ-038 With LATENCY=2, store word 32'hDEADBEEF at 0x01000010, then load word 0x01000010 -> resp_valid 2 cycles after each acceptance; the load returns 32'hDEADBEEF with resp_err=0.
REQ-039 Store byte 8'h80 at 0x01000021, then load byte signed and load byte unsigned from 0x01000021 -> 32'hFFFFFF80 and 32'h00000080; bytes 0x01000020, 0x01000022 and 0x01000023 remain 0.
REQ-040 Load word 0x01000002, load halfword 0x01000001, and load with size=11 -> each gives resp_err=1 and rdata 32'hBADB_ADFF; storage is unchanged.
REQ-041 Load word at BASE_ADDR+4*DEPTH_WORDS-4 -> success; load word at BASE_ADDR-4 and load byte at 0xFFFFFFFF -> resp_err=1.
REQ-042 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stay stable and req_ready stays 0; IDLE is entered one cycle after resp_ready=1.
REQ-043 Accept a word store of 32'h12345678 at 0x01000040 with LATENCY=4, assert reset 2 cycles later, then load 0x01000040 -> 32'h00000000, and req_ready=1 the cycle after reset.

Source files
------------

// File: rtl/data_mem_port.sv
// Single-port byte-addressed data memory with a valid/ready request/response
// handshake, fixed access latency and fault detection for misaligned/out-of-range accesses.
module data_mem_port #(
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int          DEPTH_WORDS = 262144,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
    localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS) - 33'd1;
    localparam logic [31:0] ERR_DATA = 32'hBADB_ADFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    // NOTE: storage has no reset; it is zeroed by its declaration and survives reset.
    logic [31:0] r_mem [DEPTH_WORDS] = '{default: 32'h0};

    logic             w_accept;
    logic             w_enter_resp;
    logic [31:0]      w_acc_addr;
    logic [31:0]      w_acc_wdata;
    logic             w_acc_we;
    logic [1:0]       w_acc_size;
    logic             w_acc_unsigned;
    logic [32:0]      w_size_bytes;
    logic [32:0]      w_end;
    logic             w_misalign;
    logic             w_oob;
    logic             w_fault;
    logic [IDX_W+1:0] w_offset;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_lane;
    logic [31:0]      w_mem_word;
    logic [31:0]      w_shift;
    logic [31:0]      w_load;
    logic [31:0]      w_resp_rdata;
    logic [3:0]       w_wmask;
    logic [31:0]      w_wword;

    assign w_accept     = req_valid && r_req_ready && !reset;
    assign w_enter_resp = !reset &&
                          (((r_state == IDLE) && w_accept && (LATENCY == 1)) ||
                           ((r_state == WAIT) && (r_cnt == 4'd1)));

    // With LATENCY=1 the access happens on the accepting edge, before the
    // capture registers hold the request, so the live inputs are used then.
    assign w_acc_addr     = (r_state == IDLE) ? req_addr     : r_addr;
    assign w_acc_wdata    = (r_state == IDLE) ? req_wdata    : r_wdata;
    assign w_acc_we       = (r_state == IDLE) ? req_we       : r_we;
    assign w_acc_size     = (r_state == IDLE) ? req_size     : r_size;
    assign w_acc_unsigned = (r_state == IDLE) ? req_unsigned : r_unsigned;

    always_comb begin
        w_size_bytes = 33'd1;
        w_misalign   = 1'b0;
        case (w_acc_size)
            2'b00: w_size_bytes = 33'd1;
            2'b01: begin
                w_size_bytes = 33'd2;
                w_misalign   = w_acc_addr[0];
            end
            2'b10: begin
                w_size_bytes = 33'd4;
                w_misalign   = (w_acc_addr[1:0] != 2'b00);
            end
            default: w_misalign = 1'b1;
        endcase
    end

    assign w_end   = {1'b0, w_acc_addr} + w_size_bytes - 33'd1;
    assign w_oob   = ({1'b0, w_acc_addr} < {1'b0, BASE_ADDR}) || (w_end > LIMIT);
    assign w_fault = w_misalign || w_oob;

    assign w_offset   = (IDX_W + 2)'(w_acc_addr - BASE_ADDR);
    assign w_idx      = w_offset[IDX_W+1:2];
    assign w_lane     = w_offset[1:0];
    assign w_mem_word = r_mem[w_idx];
    assign w_shift    = w_mem_word >> {w_lane, 3'b000};

    always_comb begin
        w_load = w_mem_word;
        case (w_acc_size)
            2'b00:   w_load = w_acc_unsigned ? {24'h0, w_shift[7:0]}
                                             : {{24{w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_load = w_acc_unsigned ? {16'h0, w_shift[15:0]}
                                             : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_mem_word;
        endcase
    end

    assign w_resp_rdata = w_fault ? ERR_DATA : (w_acc_we ? 32'h0 : w_load);

    always_comb begin
        w_wmask = 4'b1111;
        w_wword = w_acc_wdata;
        case (w_acc_size)
            2'b00: begin
                w_wmask = 4'b0001 << w_lane;
                w_wword = {4{w_acc_wdata[7:0]}};
            end
            2'b01: begin
                w_wmask = 4'b0011 << w_lane;
                w_wword = {2{w_acc_wdata[15:0]}};
            end
            default: begin
                w_wmask = 4'b1111;
                w_wword = w_acc_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_enter_resp && w_acc_we && !w_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wmask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_we        <= req_we;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_cnt       <= CNT_INIT;
                        r_req_ready <= 1'b0;
                        r_state     <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state      <= IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= 32'h0;
                        r_resp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase

            if (w_enter_resp) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= w_resp_rdata;
                r_resp_err   <= w_fault;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_mem_port.sv
// Directed testbench for data_mem_port: a LATENCY=2 instance for the main
// behaviour and a LATENCY=4 instance for reset-during-wait behaviour.
module tb_data_mem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        d4_reset;
    logic        d4_req_valid;
    logic        d4_req_ready;
    logic [31:0] d4_req_addr;
    logic [31:0] d4_req_wdata;
    logic        d4_req_we;
    logic [1:0]  d4_req_size;
    logic        d4_req_unsigned;
    logic        d4_resp_valid;
    logic        d4_resp_ready;
    logic [31:0] d4_resp_rdata;
    logic        d4_resp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_port u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_port #(.BASE_ADDR(32'h0100_0000), .DEPTH_WORDS(1024), .LATENCY(4)) u_dut4 (
        .clk(clk), .reset(d4_reset),
        .req_valid(d4_req_valid), .req_ready(d4_req_ready), .req_addr(d4_req_addr),
        .req_wdata(d4_req_wdata), .req_we(d4_req_we), .req_size(d4_req_size),
        .req_unsigned(d4_req_unsigned), .resp_valid(d4_resp_valid),
        .resp_ready(d4_resp_ready), .resp_rdata(d4_resp_rdata), .resp_err(d4_resp_err)
    );

    // Issue one request on the LATENCY=2 instance and collect its response.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout addr=%h req_ready=%b expected 1", addr, req_ready);
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        // Scramble the request inputs; the captured request must be used.
        req_valid = 1'b0; req_we = ~we; req_size = 2'b10; req_unsigned = ~uns;
        req_addr = 32'h0100_0010; req_wdata = 32'h5555_5555;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        if (!resp_valid) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout addr=%h resp_valid=%b expected 1", addr, resp_valid);
        end
        rdata = resp_rdata;
        err   = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    // Same handshake on the LATENCY=4 instance.
    task automatic do_req4(input logic we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!d4_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!d4_req_ready) begin
            checks++;
            errors++;
            $display("FAIL d4_req_ready_timeout addr=%h req_ready=%b expected 1", addr, d4_req_ready);
        end
        d4_req_valid = 1'b1; d4_req_we = we; d4_req_size = size; d4_req_unsigned = 1'b0;
        d4_req_addr = addr; d4_req_wdata = wdata;
        @(posedge clk);
        #1;
        d4_req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!d4_resp_valid && lat < 20);
        if (!d4_resp_valid) begin
            checks++;
            errors++;
            $display("FAIL d4_resp_timeout addr=%h resp_valid=%b expected 1", addr, d4_resp_valid);
        end
        rdata = d4_resp_rdata;
        err   = d4_resp_err;
        d4_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        d4_resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; d4_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; d4_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b valid=%b rdata=%h err=%b expected 1 0 00000000 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        checks++;
        if (d4_req_ready !== 1'b1 || d4_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL d4_reset_outputs ready=%b valid=%b expected 1 0", d4_req_ready, d4_resp_valid);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'b10, 1'b0, 32'h0100_0010, 32'hDEAD_BEEF, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || lat != 2) begin
            errors++;
            $display("FAIL store_word rdata=%h err=%b lat=%0d expected 00000000 0 2", rd, er, lat);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h0100_0010, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat != 2) begin
            errors++;
            $display("FAIL load_word rdata=%h err=%b lat=%0d expected deadbeef 0 2", rd, er, lat);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd; logic er; int lat;
        logic [31:0] addrs [4] = '{32'h0100_0020, 32'h0100_0022, 32'h0100_0023, 32'h0100_0021};
        do_req(1'b1, 2'b00, 1'b0, 32'h0100_0021, 32'hAAAA_AA80, rd, er, lat);
        do_req(1'b0, 2'b00, 1'b0, 32'h0100_0021, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFF_FF80 || er !== 1'b0) begin
            errors++;
            $display("FAIL load_byte_signed rdata=%h err=%b expected ffffff80 0", rd, er);
        end
        do_req(1'b0, 2'b00, 1'b1, addrs[3], 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000_0080 || er !== 1'b0) begin
            errors++;
            $display("FAIL load_byte_unsigned rdata=%h err=%b expected 00000080 0", rd, er);
        end
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, 2'b00, 1'b1, addrs[i], 32'h0, rd, er, lat);
            checks++;
            if (rd !== 32'h0 || er !== 1'b0) begin
                errors++;
                $display("FAIL neighbour_byte addr=%h rdata=%h err=%b expected 00000000 0", addrs[i], rd, er);
            end
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h0100_0020, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000_8000) begin
            errors++;
            $display("FAIL byte_in_word rdata=%h expected 00008000", rd);
        end
        do_req(1'b0, 2'b01, 1'b0, 32'h0100_0020, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFF_8000 || er !== 1'b0) begin
            errors++;
            $display("FAIL load_half_signed rdata=%h err=%b expected ffff8000 0", rd, er);
        end
        do_req(1'b1, 2'b01, 1'b0, 32'h0100_0032, 32'hFFFF_1234, rd, er, lat);
        do_req(1'b0, 2'b10, 1'b0, 32'h0100_0030, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h1234_0000) begin
            errors++;
            $display("FAIL store_half_upper rdata=%h expected 12340000", rd);
        end
    endtask

    task automatic test_faults();
        logic [31:0] rd; logic er; int lat;
        logic [31:0] f_addr [3] = '{32'h0100_0002, 32'h0100_0001, 32'h0100_0010};
        logic [1:0]  f_size [3] = '{2'b10, 2'b01, 2'b11};
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, f_size[i], 1'b0, f_addr[i], 32'h0, rd, er, lat);
            checks++;
            if (rd !== 32'hBADB_ADFF || er !== 1'b1 || lat != 2) begin
                errors++;
                $display("FAIL fault_load%0d rdata=%h err=%b lat=%0d expected badbadff 1 2", i, rd, er, lat);
            end
        end
        do_req(1'b1, 2'b10, 1'b0, 32'h0100_0012, 32'h1111_1111, rd, er, lat);
        checks++;
        if (rd !== 32'hBADB_ADFF || er !== 1'b1) begin
            errors++;
            $display("FAIL fault_store rdata=%h err=%b expected badbadff 1", rd, er);
        end
        do_req(1'b1, 2'b11, 1'b0, 32'h0100_0010, 32'h2222_2222, rd, er, lat);
        do_req(1'b0, 2'b10, 1'b0, 32'h0100_0010, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL fault_no_modify rdata=%h err=%b expected deadbeef 0", rd, er);
        end
    endtask

    task automatic test_bounds();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, 2'b10, 1'b0, 32'h010F_FFFC, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL top_word_load rdata=%h err=%b expected 00000000 0", rd, er);
        end
        do_req(1'b1, 2'b10, 1'b0, 32'h010F_FFFC, 32'hCAFE_F00D, rd, er, lat);
        do_req(1'b0, 2'b01, 1'b1, 32'h010F_FFFE, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000_CAFE || er !== 1'b0) begin
            errors++;
            $display("FAIL top_half_load rdata=%h err=%b expected 0000cafe 0", rd, er);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h00FF_FFFC, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hBADB_ADFF || er !== 1'b1) begin
            errors++;
            $display("FAIL below_base rdata=%h err=%b expected badbadff 1", rd, er);
        end
        do_req(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hBADB_ADFF || er !== 1'b1) begin
            errors++;
            $display("FAIL byte_ffffffff rdata=%h err=%b expected badbadff 1", rd, er);
        end
        do_req(1'b0, 2'b10, 1'b0, 32'h0110_0000, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hBADB_ADFF || er !== 1'b1) begin
            errors++;
            $display("FAIL past_top rdata=%h err=%b expected badbadff 1", rd, er);
        end
    endtask

    task automatic test_hold();
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0100_0010; req_wdata = 32'h0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 20);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d valid=%b rdata=%h ready=%b expected 1 deadbeef 0",
                         i, resp_valid, resp_rdata, req_ready);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL hold_release ready=%b valid=%b rdata=%h expected 1 0 00000000",
                     req_ready, resp_valid, resp_rdata);
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd; logic er; int lat;
        @(negedge clk);
        d4_req_valid = 1'b1; d4_req_we = 1'b1; d4_req_size = 2'b10;
        d4_req_addr = 32'h0100_0040; d4_req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        d4_req_valid = 1'b0;
        @(posedge clk);
        #1;
        d4_reset = 1'b1;
        @(posedge clk);
        #1;
        d4_reset = 1'b0;
        checks++;
        if (d4_req_ready !== 1'b1 || d4_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_wait ready=%b valid=%b expected 1 0", d4_req_ready, d4_resp_valid);
        end
        repeat (6) @(posedge clk);
        do_req4(1'b0, 2'b10, 32'h0100_0040, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || lat != 4) begin
            errors++;
            $display("FAIL discarded_store rdata=%h err=%b lat=%0d expected 00000000 0 4", rd, er, lat);
        end
        // Reset wins over a simultaneous request.
        @(negedge clk);
        d4_reset = 1'b1; d4_req_valid = 1'b1; d4_req_we = 1'b1;
        d4_req_addr = 32'h0100_0044; d4_req_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        d4_reset = 1'b0; d4_req_valid = 1'b0;
        repeat (6) @(posedge clk);
        checks++;
        if (d4_req_ready !== 1'b1 || d4_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority ready=%b valid=%b expected 1 0", d4_req_ready, d4_resp_valid);
        end
        do_req4(1'b0, 2'b10, 32'h0100_0044, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority_store rdata=%h err=%b expected 00000000 0", rd, er);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; resp_ready = 1'b0;
        d4_reset = 1'b1; d4_req_valid = 1'b0; d4_req_addr = 32'h0; d4_req_wdata = 32'h0;
        d4_req_we = 1'b0; d4_req_size = 2'b00; d4_req_unsigned = 1'b0; d4_resp_ready = 1'b0;
        test_reset();
        test_word();
        test_byte_half();
        test_faults();
        test_bounds();
        test_hold();
        test_reset_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
